// File: rtl/video_frame_pipe.sv
// video_frame_pipe: sync/timing generator plus an N-layer priority compositor.
// It emits the raster position to external layer sources and registers their
// colour/enable returns through two stages. Sync, display-enable and RGB leave
// the block on the same clock, aligned to each other.
//
// Ports:
//   clk_i, rst_ni                 pixel clock, async active-low reset
//   hpos_o, vpos_o, active_o      stage-0 raster position and active flag (to layer sources)
//   layer_enable_i, layer_rgb_i   per-layer opaque flag and {r,g,b} colour for hpos_o/vpos_o
//   hsync_no, vsync_no            active-low syncs, pipeline-aligned
//   display_enable_o              active-area flag, pipeline-aligned
//   red_o, green_o, blue_o        output colour channels
//   frame_start_o                 one-clock pulse with output pixel (0,0)
//   frame_cnt_o                   completed-frame counter
module video_frame_pipe #(
    parameter int unsigned COLOR_BITS = 24,
    parameter int unsigned NUM_LAYERS = 2,
    parameter int unsigned POS_BITS   = 10,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter logic [COLOR_BITS-1:0] BG_COLOR = '0
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    output logic [POS_BITS-1:0]              hpos_o,
    output logic [POS_BITS-1:0]              vpos_o,
    output logic                             active_o,
    input  logic [NUM_LAYERS-1:0]            layer_enable_i,
    input  logic [NUM_LAYERS*COLOR_BITS-1:0] layer_rgb_i,
    output logic                             hsync_no,
    output logic                             vsync_no,
    output logic                             display_enable_o,
    output logic [COLOR_BITS/3-1:0]          red_o,
    output logic [COLOR_BITS/3-1:0]          green_o,
    output logic [COLOR_BITS/3-1:0]          blue_o,
    output logic                             frame_start_o,
    output logic [15:0]                      frame_cnt_o
);

    localparam int unsigned CH_BITS  = COLOR_BITS / 3;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

    // Parameter legality checks at elaboration
    if (64'(H_TOTAL) > (64'(1) << POS_BITS)) begin : g_bad_h_total
        $fatal(1, "video_frame_pipe: H_TOTAL does not fit in POS_BITS");
    end
    if (64'(V_TOTAL) > (64'(1) << POS_BITS)) begin : g_bad_v_total
        $fatal(1, "video_frame_pipe: V_TOTAL does not fit in POS_BITS");
    end
    if ((COLOR_BITS % 3) != 0) begin : g_bad_color_bits
        $fatal(1, "video_frame_pipe: COLOR_BITS must be a multiple of 3");
    end

    // Stage 0: raster counters
    logic [POS_BITS-1:0] hpos_q, vpos_q;
    logic                h_last_c, v_last_c;

    assign h_last_c = (hpos_q == POS_BITS'(H_TOTAL - 1));
    assign v_last_c = (vpos_q == POS_BITS'(V_TOTAL - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hpos_q <= '0;
            vpos_q <= '0;
        end else begin
            if (h_last_c) begin
                hpos_q <= '0;
                vpos_q <= v_last_c ? '0 : vpos_q + POS_BITS'(1);
            end else begin
                hpos_q <= hpos_q + POS_BITS'(1);
            end
        end
    end

    // Stage 0 decode of the raw timing flags
    logic active_c, hsync_c, vsync_c, frame_first_c;

    assign active_c      = (hpos_q < POS_BITS'(H_ACTIVE)) && (vpos_q < POS_BITS'(V_ACTIVE));
    assign hsync_c       = (hpos_q >= POS_BITS'(HS_START)) && (hpos_q < POS_BITS'(HS_END));
    assign vsync_c       = (vpos_q >= POS_BITS'(VS_START)) && (vpos_q < POS_BITS'(VS_END));
    assign frame_first_c = (hpos_q == '0) && (vpos_q == '0);

    assign hpos_o   = hpos_q;
    assign vpos_o   = vpos_q;
    assign active_o = active_c;

    // Priority select: lowest enabled index wins, background otherwise
    logic [COLOR_BITS-1:0] layer_sel_c;

    always_comb begin
        layer_sel_c = BG_COLOR;
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (layer_enable_i[i]) begin
                layer_sel_c = layer_rgb_i[i*COLOR_BITS +: COLOR_BITS];
            end
        end
    end

    // Stage 1: composited colour and raw timing flags (syncs kept active-high here)
    logic [COLOR_BITS-1:0] s1_rgb_q;
    logic                  s1_active_q, s1_hsync_q, s1_vsync_q, s1_frame_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_rgb_q    <= '0;
            s1_active_q <= 1'b0;
            s1_hsync_q  <= 1'b0;
            s1_vsync_q  <= 1'b0;
            s1_frame_q  <= 1'b0;
        end else begin
            s1_rgb_q    <= layer_sel_c;
            s1_active_q <= active_c;
            s1_hsync_q  <= hsync_c;
            s1_vsync_q  <= vsync_c;
            s1_frame_q  <= frame_first_c;
        end
    end

    // Stage 2: blanking forced outside the active area, syncs inverted to active-low
    logic [COLOR_BITS-1:0] s2_rgb_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_rgb_q         <= '0;
            display_enable_o <= 1'b0;
            hsync_no         <= 1'b1;
            vsync_no         <= 1'b1;
            frame_start_o    <= 1'b0;
        end else begin
            s2_rgb_q         <= s1_active_q ? s1_rgb_q : '0;
            display_enable_o <= s1_active_q;
            hsync_no         <= ~s1_hsync_q;
            vsync_no         <= ~s1_vsync_q;
            frame_start_o    <= s1_frame_q;
        end
    end

    assign red_o   = s2_rgb_q[COLOR_BITS-1 -: CH_BITS];
    assign green_o = s2_rgb_q[2*CH_BITS-1 -: CH_BITS];
    assign blue_o  = s2_rgb_q[CH_BITS-1:0];

    // Frame counter steps on the same edge that raises frame_start_o; the first
    // frame start after reset only arms the counter.
    logic first_seen_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            first_seen_q <= 1'b0;
            frame_cnt_o  <= '0;
        end else if (s1_frame_q) begin
            first_seen_q <= 1'b1;
            if (first_seen_q) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_frame_pipe.sv
// Directed bench for video_frame_pipe: a default-timing instance (two layers)
// and a small-timing instance (one layer, non-zero background).
module tb_video_frame_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    // Default-timing instance
    logic [9:0]  hpos_a, vpos_a;
    logic        act_a, hs_a, vs_a, de_a, fs_a;
    logic [1:0]  en_a;
    logic [47:0] lrgb_a;
    logic [7:0]  r_a, g_a, b_a;
    logic [15:0] fc_a;

    video_frame_pipe dut_a (
        .clk_i            (clk),
        .rst_ni           (rst_a),
        .hpos_o           (hpos_a),
        .vpos_o           (vpos_a),
        .active_o         (act_a),
        .layer_enable_i   (en_a),
        .layer_rgb_i      (lrgb_a),
        .hsync_no         (hs_a),
        .vsync_no         (vs_a),
        .display_enable_o (de_a),
        .red_o            (r_a),
        .green_o          (g_a),
        .blue_o           (b_a),
        .frame_start_o    (fs_a),
        .frame_cnt_o      (fc_a)
    );

    // Small-timing instance: H 8/1/2/1 (total 12), V 4/1/1/1 (total 7)
    logic [9:0]  hpos_b, vpos_b;
    logic        act_b, hs_b, vs_b, de_b, fs_b;
    logic [0:0]  en_b;
    logic [23:0] lrgb_b;
    logic [7:0]  r_b, g_b, b_b;
    logic [15:0] fc_b;

    // Layer source: opaque on odd columns, colour encodes its own position
    assign en_b   = hpos_b[0];
    assign lrgb_b = {8'(hpos_b), 8'(vpos_b), 8'h55};

    video_frame_pipe #(
        .NUM_LAYERS (1),
        .H_ACTIVE   (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE   (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .BG_COLOR   (24'h0A0B0C)
    ) dut_b (
        .clk_i            (clk),
        .rst_ni           (rst_b),
        .hpos_o           (hpos_b),
        .vpos_o           (vpos_b),
        .active_o         (act_b),
        .layer_enable_i   (en_b),
        .layer_rgb_i      (lrgb_b),
        .hsync_no         (hs_b),
        .vsync_no         (vs_b),
        .display_enable_o (de_b),
        .red_o            (r_b),
        .green_o          (g_b),
        .blue_o           (b_b),
        .frame_start_o    (fs_b),
        .frame_cnt_o      (fc_b)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int t_b      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance until dut_a shows the given hpos (bounded); false on timeout
    task automatic wait_ha(input int h, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (32'(hpos_a) == 32'(h)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Expected small-instance outputs as a function of edges since reset release
    task automatic check_b();
        int h0, v0, p, h, v;
        bit de;
        logic [23:0] rgb;
        h0 = t_b % 12;
        v0 = (t_b / 12) % 7;
        check("b_hpos", 32'(hpos_b), 32'(h0));
        check("b_vpos", 32'(vpos_b), 32'(v0));
        check("b_active", 32'(act_b), 32'(h0 < 8 && v0 < 4));
        if (t_b < 2) begin
            check("b_hsync_rst", 32'(hs_b), 32'(1));
            check("b_vsync_rst", 32'(vs_b), 32'(1));
            check("b_de_rst", 32'(de_b), 32'(0));
            check("b_rgb_rst", 32'({r_b, g_b, b_b}), 32'(0));
            check("b_fs_rst", 32'(fs_b), 32'(0));
            check("b_fcnt_rst", 32'(fc_b), 32'(0));
        end else begin
            p  = t_b - 2;
            h  = p % 12;
            v  = (p / 12) % 7;
            de = (h < 8) && (v < 4);
            if (!de)          rgb = 24'h000000;
            else if (h % 2)   rgb = {8'(h), 8'(v), 8'h55};
            else              rgb = 24'h0A0B0C;
            check("b_hsync", 32'(hs_b), 32'(!(h >= 9 && h < 11)));
            check("b_vsync", 32'(vs_b), 32'(v != 5));
            check("b_de", 32'(de_b), 32'(de));
            check("b_rgb", 32'({r_b, g_b, b_b}), 32'(rgb));
            check("b_fs", 32'(fs_b), 32'(h == 0 && v == 0));
            check("b_fcnt", 32'(fc_b), 32'((p / 84) % 65536));
        end
    endtask

    task automatic check_b_reset(input string tag);
        check({tag, "_hsync"}, 32'(hs_b), 32'(1));
        check({tag, "_vsync"}, 32'(vs_b), 32'(1));
        check({tag, "_de"}, 32'(de_b), 32'(0));
        check({tag, "_rgb"}, 32'({r_b, g_b, b_b}), 32'(0));
        check({tag, "_fs"}, 32'(fs_b), 32'(0));
        check({tag, "_fcnt"}, 32'(fc_b), 32'(0));
        check({tag, "_hpos"}, 32'(hpos_b), 32'(0));
        check({tag, "_vpos"}, 32'(vpos_b), 32'(0));
    endtask

    initial begin
        bit ok;
        bit prev_hs;
        int cyc, fall1_h, fall1_cyc, fall2_cyc, rise_h, vs_low;

        rst_a  = 1'b0;
        rst_b  = 1'b0;
        en_a   = 2'b11;
        lrgb_a = {24'h00FF00, 24'hFF0000};
        step(3);

        // Reset state, with layers asserting colour
        check("a_rst_hsync", 32'(hs_a), 32'(1));
        check("a_rst_vsync", 32'(vs_a), 32'(1));
        check("a_rst_de", 32'(de_a), 32'(0));
        check("a_rst_rgb", 32'({r_a, g_a, b_a}), 32'(0));
        check("a_rst_fs", 32'(fs_a), 32'(0));
        check("a_rst_fcnt", 32'(fc_a), 32'(0));
        check("a_rst_hpos", 32'(hpos_a), 32'(0));
        check("a_rst_vpos", 32'(vpos_a), 32'(0));

        // Release: frame_start on the 2nd edge with pixel (0,0), layer 0 wins
        rst_a = 1'b1;
        step(1);
        check("a_edge1_fs", 32'(fs_a), 32'(0));
        check("a_edge1_hpos", 32'(hpos_a), 32'(1));
        step(1);
        check("a_edge2_fs", 32'(fs_a), 32'(1));
        check("a_edge2_de", 32'(de_a), 32'(1));
        check("a_edge2_rgb", 32'({r_a, g_a, b_a}), 32'(24'hFF0000));
        check("a_edge2_fcnt", 32'(fc_a), 32'(0));
        check("a_edge2_hpos", 32'(hpos_a), 32'(2));

        // Drop layer 0: green shows 2 clocks later
        en_a = 2'b10;
        step(1);
        check("a_l1_lag1", 32'({r_a, g_a, b_a}), 32'(24'hFF0000));
        check("a_edge3_fs", 32'(fs_a), 32'(0));
        step(1);
        check("a_l1_lag2", 32'({r_a, g_a, b_a}), 32'(24'h00FF00));

        // Drop both: background (0) 2 clocks later, still display-enabled
        en_a = 2'b00;
        step(1);
        check("a_bg_lag1", 32'({r_a, g_a, b_a}), 32'(24'h00FF00));
        step(1);
        check("a_bg_lag2", 32'({r_a, g_a, b_a}), 32'(24'h000000));
        check("a_bg_de", 32'(de_a), 32'(1));

        // Horizontal sync placement and line period
        prev_hs   = hs_a;
        fall1_h   = -1;
        fall1_cyc = -1;
        fall2_cyc = -1;
        rise_h    = -1;
        vs_low    = 0;
        for (cyc = 0; cyc < 2000; cyc++) begin
            step(1);
            if (!vs_a) vs_low++;
            if (prev_hs && !hs_a) begin
                if (fall1_cyc < 0) begin
                    fall1_cyc = cyc;
                    fall1_h   = 32'(hpos_a);
                end else begin
                    fall2_cyc = cyc;
                    break;
                end
            end
            if (!prev_hs && hs_a && fall1_cyc >= 0 && rise_h < 0) rise_h = 32'(hpos_a);
            prev_hs = hs_a;
        end
        check("a_hsync_fall_hpos", 32'(fall1_h), 32'(658));
        check("a_hsync_rise_hpos", 32'(rise_h), 32'(754));
        check("a_line_period", 32'(fall2_cyc - fall1_cyc), 32'(800));
        check("a_vsync_idle", 32'(vs_low), 32'(0));

        // Line wrap of the stage-0 counters
        wait_ha(799, ok);
        check("a_wait_799", 32'(ok), 32'(1));
        check("a_vpos_pre_wrap", 32'(vpos_a), 32'(1));
        step(1);
        check("a_hpos_wrap", 32'(hpos_a), 32'(0));
        check("a_vpos_wrap", 32'(vpos_a), 32'(2));

        // White on layer 0 across the active/blanking boundary
        en_a   = 2'b01;
        lrgb_a = {24'h00FF00, 24'hFFFFFF};
        wait_ha(102, ok);
        check("a_wait_102", 32'(ok), 32'(1));
        check("a_px100_rgb", 32'({r_a, g_a, b_a}), 32'(24'hFFFFFF));
        check("a_px100_de", 32'(de_a), 32'(1));
        check("a_h102_active", 32'(act_a), 32'(1));
        wait_ha(641, ok);
        check("a_wait_641", 32'(ok), 32'(1));
        check("a_px639_rgb", 32'({r_a, g_a, b_a}), 32'(24'hFFFFFF));
        check("a_px639_de", 32'(de_a), 32'(1));
        check("a_h641_active", 32'(act_a), 32'(0));
        step(1);
        check("a_px640_rgb", 32'({r_a, g_a, b_a}), 32'(24'h000000));
        check("a_px640_de", 32'(de_a), 32'(0));
        check("a_px640_hsync", 32'(hs_a), 32'(1));
        wait_ha(702, ok);
        check("a_wait_702", 32'(ok), 32'(1));
        check("a_px700_rgb", 32'({r_a, g_a, b_a}), 32'(24'h000000));
        check("a_px700_de", 32'(de_a), 32'(0));
        check("a_px700_hsync", 32'(hs_a), 32'(0));

        // Small instance: held in reset so far
        check_b_reset("b_hold");

        // Release and free-run past two frame starts into the third frame
        rst_b = 1'b1;
        t_b   = 0;
        check_b();
        for (int i = 0; i < 197; i++) begin
            step(1);
            t_b++;
            check_b();
        end
        check("b_pre_rst_hpos", 32'(hpos_b), 32'(5));
        check("b_pre_rst_vpos", 32'(vpos_b), 32'(2));
        check("b_pre_rst_fcnt", 32'(fc_b), 32'(2));

        // Mid-frame reset: outputs clear without waiting for a clock
        rst_b = 1'b0;
        #1;
        check_b_reset("b_async");
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_b_reset("b_held");
        end

        // Raster restarts at (0,0); run through frame starts again
        rst_b = 1'b1;
        t_b   = 0;
        check_b();
        for (int i = 0; i < 180; i++) begin
            step(1);
            t_b++;
            check_b();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/video_frame_pipe.md
Name: video_frame_pipe

Overview:
- Parametrised successor to the fixed 640x480 game top-level: one block containing a configurable sync/timing generator and an N-layer priority compositor.
- It emits the current raster position combinationally to external layer sources (map, sprites, HUD).
- It registers their colour/enable returns through a 2-stage pipeline.
- It outputs sync, display-enable and RGB aligned to each other, plus frame markers.
- It sits directly in front of the display encoder.

Parameters:
COLOR_BITS, 24, total RGB bits; each channel is COLOR_BITS/3.
NUM_LAYERS, 2, number of layer inputs; layer 0 is highest priority.
POS_BITS, 10, width of hpos_o/vpos_o.
H_ACTIVE, 640, visible pixels per line.
H_FP, 16, horizontal front porch, in clocks.
H_SYNC, 96, horizontal sync width, in clocks.
H_BP, 48, horizontal back porch, in clocks.
V_ACTIVE, 480, visible lines.
V_FP, 10, vertical front porch, in lines.
V_SYNC, 2, vertical sync width, in lines.
V_BP, 33, vertical back porch, in lines.
BG_COLOR, 0, COLOR_BITS-wide {red,green,blue} shown when no layer is enabled.

Ports:
clk_i  input  1  pixel clock.
rst_ni  input  1  asynchronous active-low reset.
hpos_o  output  POS_BITS  current horizontal counter (stage 0, unregistered view of the counter flop).
vpos_o  output  POS_BITS  current vertical counter.
active_o  output  1  stage-0 active-area flag; layer sources qualify on this.
layer_enable_i  input  NUM_LAYERS  per-layer opaque flag for the current hpos_o/vpos_o.
layer_rgb_i  input  NUM_LAYERS*COLOR_BITS  layer i colour at [i*COLOR_BITS +: COLOR_BITS], packed {red,green,blue}.
hsync_no  output  1  horizontal sync, active low, pipeline-aligned.
vsync_no  output  1  vertical sync, active low, pipeline-aligned.
display_enable_o  output  1  active-area flag, pipeline-aligned.
red_o  output  COLOR_BITS/3  red channel.
green_o  output  COLOR_BITS/3  green channel.
blue_o  output  COLOR_BITS/3  blue channel.
frame_start_o  output  1  one-clock pulse coincident with output pixel (0,0).
frame_cnt_o  output  16  completed-frame counter.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Elaboration error if either total exceeds 2^POS_BITS, or if COLOR_BITS%3 != 0.
- Stage 0 counters:
  - hpos increments every clock; at H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos wraps from V_TOTAL-1 to 0 on the same clock that hpos wraps.
  - active_o = (hpos < H_ACTIVE) && (vpos < V_ACTIVE).
  - Raw hsync is active for H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC.
  - Raw vsync is active for V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC.
- Layer inputs are sampled combinationally from stage 0 and have no internal latency.
- Stage 1 register:
  - Selects the lowest index i with layer_enable_i[i]=1 and takes its colour; otherwise BG_COLOR.
  - Also registers active, hsync, vsync and the frame-start condition (hpos==0 && vpos==0).
- Stage 2 register:
  - RGB = stage-1 colour when stage-1 active=1, else all zeros (blanking is forced even if a layer asserts enable).
  - Syncs, display_enable_o and frame_start_o are registered copies of their stage-1 values.
- Latency: every output lags hpos_o/vpos_o by exactly 2 clocks. Sync, enable and RGB must never be skewed relative to each other.
- frame_cnt_o:
  - Increments by 1 on the clock where frame_start_o is 1, except the first frame_start_o after reset.
  - Wraps 0xFFFF -> 0.
- Reset (asynchronous assert; deassert is synchronous to clk_i in the system):
  - Counters go to 0.
  - All pipeline registers clear: RGB=0, display_enable_o=0, hsync_no=1, vsync_no=1, frame_start_o=0, frame_cnt_o=0.
- Reset mid-frame: the raster restarts at (0,0) with no partial sync pulse beyond the reset edge.
- First output after reset release: frame_start_o=1 on the 2nd clock edge after release, with display_enable_o=1 and the pixel (0,0) colour.
- NUM_LAYERS=1 is legal and is a single layer over the background.

Test Plan:
- Reset, then release -> all outputs hold reset values during reset; frame_start_o=1 exactly at edge 2; frame_cnt_o stays 0.
- Default timing, free-run 2 frames -> hsync_no low for output hpos 656..751, line period 800 clocks; vsync_no low for lines 490..491, frame period 420000 clocks; frame_cnt_o=1 after the second frame_start_o.
- Layer 0 enable=1 with rgb 0xFF0000, layer 1 enable=1 with 0x00FF00 -> output red=0xFF, green=0, blue=0. Drop layer 0 -> 0x00FF00. Drop both -> BG_COLOR. Each change appears 2 clocks after the input change.
- Drive enable=1 with white during blanking (hpos 700) -> RGB outputs all 0 and display_enable_o=0.
- Small timing (H 8/1/2/1, V 4/1/1/1), assert rst_ni low at hpos=5, vpos=2 for 3 clocks -> outputs return immediately to reset values; raster resumes at (0,0); sync pulses appear at the parameterised positions.
- Force frame_cnt_o to 0xFFFF via 65536 small frames, or a backdoor preload -> next frame start wraps it to 0.
